// File: rtl/dec_scan_ctrl.sv
// Round-robin scan sequencer driving the select lines and enables of a 3-to-8 active-low decoder.
// Optional macro DEC_SCAN_WRAP_CNT_EN adds an 8-bit wrap counter output (wrap_cnt_o).
module dec_scan_ctrl #(
  parameter int DWELL_W    = 8,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [7:0]         mask_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               select_a_o,
  output logic               select_b_o,
  output logic               select_c_o,
  output logic               g1_en_o,
  output logic               g2a_en_n_o,
  output logic               g2b_en_n_o,
  output logic               busy_o,
  output logic [2:0]         chan_o,
  output logic               wrap_o
`ifdef DEC_SCAN_WRAP_CNT_EN
  ,
  output logic [7:0]         wrap_cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEEK,
    S_ACTIVE,
    S_GAP
  } state_t;

  state_t             r_state;
  logic [2:0]         r_chan;
  logic [2:0]         r_ptr;
  logic [DWELL_W-1:0] r_dwell;
  logic [3:0]         r_gap;
  logic               r_fromIdle;
  logic               r_busy;
  logic               r_wrap;
  logic               r_g1;
  logic               r_g2aN;
  logic               r_g2bN;
`ifdef DEC_SCAN_WRAP_CNT_EN
  logic [7:0]         r_wrapCnt;
`endif

  logic [2:0]         w_next;
  logic               w_goSeek;
  logic [DWELL_W-1:0] w_dwellLoad;

  // First set mask bit strictly after ptr, rotating 0..7; i=8 lands back on ptr itself.
  function automatic logic [2:0] nextChan(input logic [7:0] mask, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    nextChan = ptr;
    found    = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && mask[idx]) begin
        nextChan = idx;
        found    = 1'b1;
      end
    end
  endfunction

  assign w_next      = nextChan(mask_i, r_ptr);
  assign w_goSeek    = start_i && (mask_i != 8'h00);
  assign w_dwellLoad = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_chan     <= 3'd0;
      r_ptr      <= 3'd7;
      r_dwell    <= '0;
      r_gap      <= 4'd0;
      r_fromIdle <= 1'b0;
      r_busy     <= 1'b0;
      r_wrap     <= 1'b0;
      r_g1       <= 1'b0;
      r_g2aN     <= 1'b1;
      r_g2bN     <= 1'b1;
`ifdef DEC_SCAN_WRAP_CNT_EN
      r_wrapCnt  <= 8'd0;
`endif
    end else begin
      r_wrap <= 1'b0;
      r_g1   <= 1'b0;
      r_g2aN <= 1'b1;
      r_g2bN <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_goSeek) begin
            r_state    <= S_SEEK;
            r_fromIdle <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_SEEK: begin
          if (mask_i == 8'h00) begin
            r_state <= S_IDLE;
            r_ptr   <= 3'd7;
            r_busy  <= 1'b0;
          end else begin
            r_state    <= S_ACTIVE;
            r_chan     <= w_next;
            r_dwell    <= w_dwellLoad;
            r_fromIdle <= 1'b0;
            r_wrap     <= (w_next <= r_ptr) && !r_fromIdle;
`ifdef DEC_SCAN_WRAP_CNT_EN
            if ((w_next <= r_ptr) && !r_fromIdle)
              r_wrapCnt <= r_wrapCnt + 8'd1;
`endif
            r_g1       <= 1'b1;
            r_g2aN     <= 1'b0;
            r_g2bN     <= 1'b0;
          end
        end
        S_ACTIVE: begin
          r_ptr <= r_chan;
          if (r_dwell <= DWELL_W'(1)) begin
            r_dwell <= '0;
            if (GAP_CYCLES > 0) begin
              r_state <= S_GAP;
              r_gap   <= 4'(GAP_CYCLES);
            end else if (w_goSeek) begin
              r_state <= S_SEEK;
            end else begin
              r_state <= S_IDLE;
              r_ptr   <= 3'd7;
              r_busy  <= 1'b0;
            end
          end else begin
            r_dwell <= r_dwell - DWELL_W'(1);
            r_g1    <= 1'b1;
            r_g2aN  <= 1'b0;
            r_g2bN  <= 1'b0;
          end
        end
        S_GAP: begin
          // Selects are left untouched here so the decoder inputs never glitch while disabled.
          if (r_gap <= 4'd1) begin
            r_gap <= 4'd0;
            if (w_goSeek) begin
              r_state <= S_SEEK;
            end else begin
              r_state <= S_IDLE;
              r_ptr   <= 3'd7;
              r_busy  <= 1'b0;
            end
          end else begin
            r_gap <= r_gap - 4'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign select_a_o = r_chan[0];
  assign select_b_o = r_chan[1];
  assign select_c_o = r_chan[2];
  assign chan_o     = r_chan;
  assign g1_en_o    = r_g1;
  assign g2a_en_n_o = r_g2aN;
  assign g2b_en_n_o = r_g2bN;
  assign busy_o     = r_busy;
  assign wrap_o     = r_wrap;
`ifdef DEC_SCAN_WRAP_CNT_EN
  assign wrap_cnt_o = r_wrapCnt;
`endif

endmodule
